// File: rtl/sha256_round_ctrl.sv
// SHA-256 compression round controller: sequences ROUNDS rounds through an
// external combinational round datapath and forms the block digest.
module sha256_round_ctrl #(
    parameter int ROUNDS = 64
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         v_i,
    input  logic [255:0] hash_i,
    output logic         ready_o,
    output logic [5:0]   round_o,
    output logic         round_v_o,
    output logic [255:0] state_o,
    input  logic [255:0] next_state_i,
    output logic         v_o,
    output logic [255:0] digest_o,
    input  logic         yumi_i
);

    typedef enum logic [1:0] {IDLE, RUN, ADD, DONE} fsm_t;

    localparam logic [5:0] LAST = 6'(ROUNDS - 1);

    fsm_t         fsm, fsm_nxt;
    logic [5:0]   cnt;
    logic [255:0] work, hash, digest;
    logic [255:0] sum;
    logic         last;

    assign last = (cnt == LAST);

    always_comb begin
        fsm_nxt   = fsm;
        ready_o   = 1'b0;
        round_v_o = 1'b0;
        v_o       = 1'b0;
        case (fsm)
            IDLE: begin
                ready_o = 1'b1;
                if (v_i) fsm_nxt = RUN;
            end
            RUN: begin
                round_v_o = 1'b1;
                if (last) fsm_nxt = ADD;
            end
            ADD: fsm_nxt = DONE;
            DONE: begin
                v_o = 1'b1;
                if (yumi_i) fsm_nxt = IDLE;
            end
            default: fsm_nxt = IDLE;
        endcase
    end

    // Word-wise feed-forward; each 32-bit lane wraps on its own.
    always_comb begin
        sum = '0;
        for (int i = 0; i < 8; i++)
            sum[32*i +: 32] = work[32*i +: 32] + hash[32*i +: 32];
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            fsm    <= IDLE;
            cnt    <= '0;
            work   <= '0;
            hash   <= '0;
            digest <= '0;
        end else begin
            fsm <= fsm_nxt;
            case (fsm)
                IDLE: if (v_i) begin
                    hash <= hash_i;
                    work <= hash_i;
                    cnt  <= '0;
                end
                RUN: begin
                    work <= next_state_i;
                    // Counter returns to 0 on the last round so it never wraps.
                    cnt  <= last ? 6'd0 : cnt + 6'd1;
                end
                ADD: digest <= sum;
                default: ;
            endcase
        end
    end

    assign round_o  = cnt;
    assign state_o  = work;
    assign digest_o = digest;

endmodule

// File: tb/tb_sha256_round_ctrl.sv
// Directed bench for sha256_round_ctrl: stub and real SHA-256 datapaths,
// stall, reset abort and a ROUNDS=2 instance.
module tb_sha256_round_ctrl;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         v_a = 1'b0, yumi_a = 1'b0, use_real = 1'b0;
    logic [255:0] hash_a = '0, ns_a;
    logic         ready_a, rv_a, vo_a;
    logic [5:0]   round_a;
    logic [255:0] state_a, dig_a;

    logic         v_b = 1'b0, yumi_b = 1'b0;
    logic [255:0] hash_b = '0, ns_b;
    logic         ready_b, rv_b, vo_b;
    logic [5:0]   round_b;
    logic [255:0] state_b, dig_b;

    int n_chk = 0;
    int n_fail = 0;

    logic [31:0] k [64];
    logic [31:0] w [64];

    always #5 clk = ~clk;

    sha256_round_ctrl #(.ROUNDS(64)) dut_a (
        .clk_i(clk), .reset_i(reset_n), .v_i(v_a), .hash_i(hash_a),
        .ready_o(ready_a), .round_o(round_a), .round_v_o(rv_a),
        .state_o(state_a), .next_state_i(ns_a), .v_o(vo_a),
        .digest_o(dig_a), .yumi_i(yumi_a));

    sha256_round_ctrl #(.ROUNDS(2)) dut_b (
        .clk_i(clk), .reset_i(reset_n), .v_i(v_b), .hash_i(hash_b),
        .ready_o(ready_b), .round_o(round_b), .round_v_o(rv_b),
        .state_o(state_b), .next_state_i(ns_b), .v_o(vo_b),
        .digest_o(dig_b), .yumi_i(yumi_b));

    function automatic logic [255:0] inc8(input logic [255:0] s);
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[32*i +: 32] = s[32*i +: 32] + 32'd1;
        return r;
    endfunction

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] sha_rnd(input logic [255:0] s,
                                             input logic [31:0] wt, kt);
        logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
        {a, b, c, d, e, f, g, h} = s;
        t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + kt + wt;
        t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
        return {t1 + t2, a, b, c, d + t1, e, f, g};
    endfunction

    always_comb ns_a = use_real ? sha_rnd(state_a, w[round_a], k[round_a]) : inc8(state_a);
    always_comb ns_b = inc8(state_b);

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives a stub block on dut_a from IDLE to DONE without checking.
    task automatic run_to_done_a(input logic [255:0] h);
        hash_a = h; v_a = 1'b1;
        step();
        v_a = 1'b0;
        repeat (66) step();
    endtask

    task automatic test_reset();
        reset_n = 1'b0; v_a = 1'b1; yumi_a = 1'b1;
        step();
        n_chk++; if (ready_a !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", ready_a); end
        n_chk++; if (vo_a !== 1'b0) begin n_fail++; $display("FAIL reset_v got %b want 0", vo_a); end
        n_chk++; if (rv_a !== 1'b0 || round_a !== 6'd0) begin n_fail++; $display("FAIL reset_round got v=%b r=%0d want 0/0", rv_a, round_a); end
        n_chk++; if (state_a !== '0 || dig_a !== '0) begin n_fail++; $display("FAIL reset_regs got state=%h dig=%h want 0", state_a, dig_a); end
        n_chk++; if (ready_b !== 1'b1 || vo_b !== 1'b0) begin n_fail++; $display("FAIL reset_b got rdy=%b v=%b want 1/0", ready_b, vo_b); end
        // v_i asserted under reset must not start a block.
        step();
        n_chk++; if (rv_a !== 1'b0) begin n_fail++; $display("FAIL reset_prio got round_v=%b want 0", rv_a); end
        reset_n = 1'b1; v_a = 1'b0; yumi_a = 1'b0;
        step();
    endtask

    task automatic test_stub_zero();
        hash_a = '0; v_a = 1'b1;
        step();
        v_a = 1'b0;
        for (int t = 0; t < 64; t++) begin
            n_chk++;
            if (rv_a !== 1'b1 || round_a !== 6'(t) || ready_a !== 1'b0 || state_a !== {8{32'(t)}} || vo_a !== 1'b0) begin
                n_fail++;
                $display("FAIL run_t%0d got rv=%b r=%0d rdy=%b st=%h vo=%b", t, rv_a, round_a, ready_a, state_a, vo_a);
            end
            v_a = 1'b1;  // ignored outside IDLE
            step();
        end
        v_a = 1'b0;
        n_chk++; if (rv_a !== 1'b0 || round_a !== 6'd0 || vo_a !== 1'b0) begin n_fail++; $display("FAIL add_cycle got rv=%b r=%0d vo=%b want 0/0/0", rv_a, round_a, vo_a); end
        step();
        n_chk++; if (vo_a !== 1'b1) begin n_fail++; $display("FAIL latency66 got v_o=%b want 1", vo_a); end
        n_chk++; if (dig_a !== {8{32'h0000_0040}}) begin n_fail++; $display("FAIL digest_40 got %h want %h", dig_a, {8{32'h0000_0040}}); end
        yumi_a = 1'b1;
        step();
        yumi_a = 1'b0;
        n_chk++; if (ready_a !== 1'b1 || vo_a !== 1'b0) begin n_fail++; $display("FAIL yumi_idle got rdy=%b v=%b want 1/0", ready_a, vo_a); end
    endtask

    // FFFFFFFF + 64 rounds of +1 = 0x3F per word; adding back FFFFFFFF wraps to 0x3E.
    task automatic test_wrap();
        int first;
        first = -1;
        hash_a = {8{32'hFFFF_FFFF}}; v_a = 1'b1; yumi_a = 1'b1;
        step();
        v_a = 1'b0;
        for (int c = 1; c <= 70; c++) begin
            if (vo_a === 1'b1 && first < 0) first = c;
            if (first < 0) step();
        end
        n_chk++; if (first != 66) begin n_fail++; $display("FAIL wrap_latency got cycle %0d want 66", first); end
        n_chk++; if (dig_a !== {8{32'h0000_003E}}) begin n_fail++; $display("FAIL digest_wrap got %h want %h", dig_a, {8{32'h0000_003E}}); end
        step();
        yumi_a = 1'b0;
        n_chk++; if (ready_a !== 1'b1) begin n_fail++; $display("FAIL wrap_to_idle got rdy=%b want 1", ready_a); end
    endtask

    task automatic test_abc();
        logic [255:0] exp;
        exp = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
        for (int i = 0; i < 16; i++) w[i] = 32'h0;
        w[0] = 32'h6162_6380; w[15] = 32'h0000_0018;
        for (int t = 16; t < 64; t++)
            w[t] = (rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
                 + (rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
        use_real = 1'b1;
        run_to_done_a({32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                       32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19});
        n_chk++; if (vo_a !== 1'b1 || dig_a !== exp) begin n_fail++; $display("FAIL abc_digest got v=%b %h want %h", vo_a, dig_a, exp); end
        use_real = 1'b0;
        yumi_a = 1'b1;
        step();
        yumi_a = 1'b0;
    endtask

    task automatic test_stall();
        run_to_done_a('0);
        v_a = 1'b1; hash_a = {8{32'h1234_5678}};
        for (int i = 0; i < 10; i++) begin
            n_chk++;
            if (vo_a !== 1'b1 || ready_a !== 1'b0 || rv_a !== 1'b0 || dig_a !== {8{32'h40}}) begin
                n_fail++;
                $display("FAIL stall_%0d got v=%b rdy=%b rv=%b dig=%h", i, vo_a, ready_a, rv_a, dig_a);
            end
            step();
        end
        yumi_a = 1'b1;
        step();
        yumi_a = 1'b0; hash_a = '0;
        n_chk++; if (ready_a !== 1'b1 || vo_a !== 1'b0) begin n_fail++; $display("FAIL stall_release got rdy=%b v=%b want 1/0", ready_a, vo_a); end
        step();
        v_a = 1'b0;
        n_chk++; if (rv_a !== 1'b1 || round_a !== 6'd0 || state_a !== '0) begin n_fail++; $display("FAIL stall_accept got rv=%b r=%0d st=%h", rv_a, round_a, state_a); end
        repeat (65) step();
        n_chk++; if (vo_a !== 1'b1 || dig_a !== {8{32'h40}}) begin n_fail++; $display("FAIL stall_next got v=%b dig=%h", vo_a, dig_a); end
        yumi_a = 1'b1;
        step();
        yumi_a = 1'b0;
    endtask

    task automatic test_reset_mid();
        int stray;
        hash_a = {8{32'h0000_1000}}; v_a = 1'b1;
        step();
        v_a = 1'b0;
        repeat (30) step();
        n_chk++; if (round_a !== 6'd30) begin n_fail++; $display("FAIL mid_round got %0d want 30", round_a); end
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        n_chk++;
        if (ready_a !== 1'b1 || vo_a !== 1'b0 || rv_a !== 1'b0 || round_a !== 6'd0 || state_a !== '0 || dig_a !== '0) begin
            n_fail++;
            $display("FAIL mid_reset got rdy=%b v=%b rv=%b r=%0d st=%h dig=%h", ready_a, vo_a, rv_a, round_a, state_a, dig_a);
        end
        stray = 0;
        hash_a = '0; v_a = 1'b1;
        step();
        v_a = 1'b0;
        for (int c = 1; c < 66; c++) begin
            if (vo_a === 1'b1) stray++;
            step();
        end
        n_chk++; if (stray != 0) begin n_fail++; $display("FAIL mid_stray got %0d early v_o cycles want 0", stray); end
        n_chk++; if (vo_a !== 1'b1 || dig_a !== {8{32'h40}}) begin n_fail++; $display("FAIL mid_fresh got v=%b dig=%h", vo_a, dig_a); end
        // Reset while in DONE drops the digest with no handshake.
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        n_chk++; if (vo_a !== 1'b0 || ready_a !== 1'b1 || dig_a !== '0) begin n_fail++; $display("FAIL done_reset got v=%b rdy=%b dig=%h", vo_a, ready_a, dig_a); end
    endtask

    task automatic test_rounds2();
        hash_b = '0; v_b = 1'b1;
        step();
        v_b = 1'b0;
        n_chk++; if (rv_b !== 1'b1 || round_b !== 6'd0) begin n_fail++; $display("FAIL r2_c1 got rv=%b r=%0d want 1/0", rv_b, round_b); end
        step();
        n_chk++; if (rv_b !== 1'b1 || round_b !== 6'd1) begin n_fail++; $display("FAIL r2_c2 got rv=%b r=%0d want 1/1", rv_b, round_b); end
        step();
        n_chk++; if (rv_b !== 1'b0 || vo_b !== 1'b0) begin n_fail++; $display("FAIL r2_add got rv=%b v=%b want 0/0", rv_b, vo_b); end
        step();
        n_chk++; if (vo_b !== 1'b1 || dig_b !== {8{32'h2}}) begin n_fail++; $display("FAIL r2_digest got v=%b dig=%h want 1/%h", vo_b, dig_b, {8{32'h2}}); end
        yumi_b = 1'b1;
        step();
        yumi_b = 1'b0;
        n_chk++; if (ready_b !== 1'b1 || vo_b !== 1'b0) begin n_fail++; $display("FAIL r2_idle got rdy=%b v=%b", ready_b, vo_b); end
    endtask

    initial begin
        k = '{32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
              32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
              32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
              32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
              32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
              32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
              32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
              32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};
        for (int i = 0; i < 64; i++) w[i] = 32'h0;
        #1;
        test_reset();
        test_stub_zero();
        test_wrap();
        test_abc();
        test_stall();
        test_reset_mid();
        test_rounds2();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
